// File: rtl/router_fsm.sv
// Control FSM for the 1x3 router: decodes the header address, tracks packet progress,
// handles output-FIFO back-pressure and per-port soft resets, and emits datapath strobes.
module router_fsm (
   input  logic       clock,
   input  logic       resetn,
   input  logic       pkt_valid,
   input  logic [1:0] data_in,
   input  logic       fifo_full,
   input  logic       fifo_empty_0,
   input  logic       fifo_empty_1,
   input  logic       fifo_empty_2,
   input  logic       soft_reset_0,
   input  logic       soft_reset_1,
   input  logic       soft_reset_2,
   input  logic       parity_done,
   input  logic       low_packet_valid,
   output logic       detect_add,
   output logic       lfd_state,
   output logic       ld_state,
   output logic       laf_state,
   output logic       full_state,
   output logic       rst_int_reg,
   output logic       write_enb_reg,
   output logic       busy,
   output logic [1:0] active_port
);

   typedef enum logic [2:0] {
      DECODE_ADDRESS,
      LOAD_FIRST_DATA,
      LOAD_DATA,
      FIFO_FULL_STATE,
      LOAD_AFTER_FULL,
      LOAD_PARITY,
      CHECK_PARITY_ERROR,
      WAIT_TILL_EMPTY
   } state_t;

   state_t     state;
   state_t     next_state;
   logic [1:0] addr_reg;
   logic       din_empty;
   logic       addr_empty;
   logic       soft_hit;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state    <= DECODE_ADDRESS;
         addr_reg <= 2'b00;
      end else begin
         state <= next_state;
         if (state == DECODE_ADDRESS && pkt_valid && data_in != 2'b11)
            addr_reg <= data_in;
      end
   end

   // Empty flag for the incoming header address and for the latched address
   always_comb begin
      din_empty = 1'b0;
      case (data_in)
         2'd0:    din_empty = fifo_empty_0;
         2'd1:    din_empty = fifo_empty_1;
         2'd2:    din_empty = fifo_empty_2;
         default: din_empty = 1'b0;
      endcase
      addr_empty = 1'b0;
      case (addr_reg)
         2'd0:    addr_empty = fifo_empty_0;
         2'd1:    addr_empty = fifo_empty_1;
         2'd2:    addr_empty = fifo_empty_2;
         default: addr_empty = 1'b0;
      endcase
   end

   assign soft_hit = (addr_reg == 2'd0 && soft_reset_0) ||
                     (addr_reg == 2'd1 && soft_reset_1) ||
                     (addr_reg == 2'd2 && soft_reset_2);

   always_comb begin
      next_state = state;
      if (soft_hit) begin
         next_state = DECODE_ADDRESS;
      end else begin
         case (state)
            DECODE_ADDRESS:
               if (pkt_valid && data_in != 2'b11)
                  next_state = din_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            WAIT_TILL_EMPTY:
               if (addr_empty) next_state = LOAD_FIRST_DATA;
            LOAD_FIRST_DATA:
               next_state = LOAD_DATA;
            LOAD_DATA:
               if (fifo_full)       next_state = FIFO_FULL_STATE;
               else if (!pkt_valid) next_state = LOAD_PARITY;
            FIFO_FULL_STATE:
               if (!fifo_full) next_state = LOAD_AFTER_FULL;
            LOAD_AFTER_FULL:
               if (parity_done)           next_state = DECODE_ADDRESS;
               else if (low_packet_valid) next_state = LOAD_PARITY;
               else                       next_state = LOAD_DATA;
            LOAD_PARITY:
               next_state = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR:
               next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            default:
               next_state = DECODE_ADDRESS;
         endcase
      end
   end

   assign detect_add    = (state == DECODE_ADDRESS);
   assign lfd_state     = (state == LOAD_FIRST_DATA);
   assign ld_state      = (state == LOAD_DATA);
   assign laf_state     = (state == LOAD_AFTER_FULL);
   assign full_state    = (state == FIFO_FULL_STATE);
   assign rst_int_reg   = (state == CHECK_PARITY_ERROR);
   assign write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) ||
                          (state == LOAD_AFTER_FULL);
   assign busy          = (state != DECODE_ADDRESS) && (state != LOAD_DATA);
   assign active_port   = addr_reg;

endmodule

// File: tb/tb_router_fsm.sv
// Directed self-checking bench for router_fsm: walks packets through every state and
// compares the full output vector against hand-computed per-state values.
module tb_router_fsm;

   logic       clock;
   logic       resetn;
   logic       pkt_valid;
   logic [1:0] data_in;
   logic       fifo_full;
   logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
   logic       soft_reset_0, soft_reset_1, soft_reset_2;
   logic       parity_done;
   logic       low_packet_valid;
   logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
   logic       write_enb_reg, busy;
   logic [1:0] active_port;
   logic [9:0] out_vec;

   int tests_run    = 0;
   int tests_failed = 0;
   int wen_count    = 0;

   // Expected {detect_add,lfd,ld,laf,full,rst_int,write_enb,busy} per state
   localparam logic [7:0] S_DEC  = 8'b1000_0000;
   localparam logic [7:0] S_LFD  = 8'b0100_0001;
   localparam logic [7:0] S_LD   = 8'b0010_0010;
   localparam logic [7:0] S_LAF  = 8'b0001_0011;
   localparam logic [7:0] S_FULL = 8'b0000_1001;
   localparam logic [7:0] S_LP   = 8'b0000_0011;
   localparam logic [7:0] S_CPE  = 8'b0000_0101;
   localparam logic [7:0] S_WTE  = 8'b0000_0001;

   router_fsm dut (
      .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
      .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
      .fifo_empty_2(fifo_empty_2), .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
      .soft_reset_2(soft_reset_2), .parity_done(parity_done),
      .low_packet_valid(low_packet_valid), .detect_add(detect_add), .lfd_state(lfd_state),
      .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
      .rst_int_reg(rst_int_reg), .write_enb_reg(write_enb_reg), .busy(busy),
      .active_port(active_port)
   );

   assign out_vec = {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
                     write_enb_reg, busy, active_port};

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      tests_run++;
      if (observed !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic checkState(input string tag, input logic [7:0] strobes,
                             input logic [1:0] port);
      checkOutput(tag, {6'd0, out_vec}, {6'd0, strobes, port});
   endtask

   // One rising edge, then sample 1 time unit later
   task automatic applyStimulus();
      @(posedge clock);
      #1;
      if (write_enb_reg) wen_count++;
   endtask

   initial begin
      resetn = 1'b0; pkt_valid = 1'b0; data_in = 2'b00; fifo_full = 1'b0;
      fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
      soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
      parity_done = 1'b0; low_packet_valid = 1'b0;
      #12;
      checkState("reset", S_DEC, 2'd0);
      resetn = 1'b1;

      // Invalid address 3 is ignored
      pkt_valid = 1'b1; data_in = 2'b11;
      applyStimulus(); checkState("invalid_addr", S_DEC, 2'd0);

      // Normal packet to port 1, four payload cycles
      data_in = 2'b01; wen_count = 0;
      applyStimulus(); checkState("norm_lfd", S_LFD, 2'd1);
      applyStimulus(); checkState("norm_ld1", S_LD, 2'd1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(); checkState("norm_ldn", S_LD, 2'd1);
      end
      pkt_valid = 1'b0;
      applyStimulus(); checkState("norm_lp", S_LP, 2'd1);
      applyStimulus(); checkState("norm_cpe", S_CPE, 2'd1);
      applyStimulus(); checkState("norm_dec", S_DEC, 2'd1);
      checkOutput("norm_wen_cycles", 16'(wen_count), 16'd5);

      // Busy FIFO on port 2
      pkt_valid = 1'b1; data_in = 2'b10; fifo_empty_2 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(); checkState("wait_empty", S_WTE, 2'd2);
      end
      fifo_empty_2 = 1'b1;
      applyStimulus(); checkState("wait_lfd", S_LFD, 2'd2);
      applyStimulus(); checkState("wait_ld", S_LD, 2'd2);

      // Back-pressure paths
      fifo_full = 1'b1;
      applyStimulus(); checkState("full1", S_FULL, 2'd2);
      applyStimulus(); checkState("full2", S_FULL, 2'd2);
      fifo_full = 1'b0;
      applyStimulus(); checkState("laf1", S_LAF, 2'd2);
      applyStimulus(); checkState("laf_to_ld", S_LD, 2'd2);
      pkt_valid = 1'b0; fifo_full = 1'b1;
      applyStimulus(); checkState("full_beats_pv", S_FULL, 2'd2);
      fifo_full = 1'b0;
      applyStimulus(); checkState("laf2", S_LAF, 2'd2);
      low_packet_valid = 1'b1;
      applyStimulus(); checkState("laf_to_lp", S_LP, 2'd2);
      low_packet_valid = 1'b0;
      applyStimulus(); checkState("bp_cpe", S_CPE, 2'd2);
      fifo_full = 1'b1;
      applyStimulus(); checkState("cpe_to_full", S_FULL, 2'd2);
      fifo_full = 1'b0;
      applyStimulus(); checkState("laf3", S_LAF, 2'd2);
      parity_done = 1'b1;
      applyStimulus(); checkState("laf_to_dec", S_DEC, 2'd2);
      parity_done = 1'b0;

      // Soft reset: other port ignored, addressed port returns to decode
      pkt_valid = 1'b1; data_in = 2'b00;
      applyStimulus(); checkState("sr_lfd", S_LFD, 2'd0);
      applyStimulus(); checkState("sr_ld", S_LD, 2'd0);
      soft_reset_1 = 1'b1;
      applyStimulus(); checkState("sr_other", S_LD, 2'd0);
      soft_reset_1 = 1'b0; soft_reset_0 = 1'b1;
      applyStimulus(); checkState("sr_own", S_DEC, 2'd0);
      soft_reset_0 = 1'b0;

      // Soft reset while waiting for port 1 to drain
      data_in = 2'b01; fifo_empty_1 = 1'b0;
      applyStimulus(); checkState("sr_wte", S_WTE, 2'd1);
      soft_reset_1 = 1'b1; pkt_valid = 1'b0;
      applyStimulus(); checkState("sr_wte_dec", S_DEC, 2'd1);
      soft_reset_1 = 1'b0;

      // Async reset in the middle of LOAD_DATA
      fifo_empty_1 = 1'b1; pkt_valid = 1'b1; data_in = 2'b01;
      applyStimulus(); checkState("ar_lfd", S_LFD, 2'd1);
      applyStimulus(); checkState("ar_ld", S_LD, 2'd1);
      #2 resetn = 1'b0;
      #1 checkState("async_reset", S_DEC, 2'd0);
      pkt_valid = 1'b0;
      @(negedge clock); resetn = 1'b1;
      applyStimulus(); checkState("post_reset", S_DEC, 2'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
